// File: rtl/wb_dbus_master_pkg.sv
// ---------------------------------------------------------------------------
// wb_dbus_master_pkg
// Shared definitions for the data-side Wishbone master:
//   - FSM state encodings (2-bit, legacy-compatible values)
//   - registered Wishbone request bundle type and its idle value
//   - saturating increment for the 16-bit timeout counter
// ---------------------------------------------------------------------------
package wb_dbus_master_pkg;

    localparam logic [1:0] WB_IDLE           = 2'b00;
    localparam logic [1:0] WB_BUSY           = 2'b01;
    localparam logic [1:0] WB_WAIT_FOR_STALL = 2'b11;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam int          TMO_W     = 16;

    // Everything the master drives onto the bus, registered as one bundle so
    // that "drop the cycle" is a single assignment of WB_REQ_IDLE.
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '0;

    // Counter sticks at all-ones rather than wrapping, so a very large or
    // disabled timeout can never produce a spurious match after wrap-around.
    function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] cnt);
        return (cnt == {TMO_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/wb_dbus_master.sv
// ---------------------------------------------------------------------------
// wb_dbus_master
// Data-side Wishbone B4 classic master sitting behind the mem stage. Accepts
// one ce/we/sel/addr/data request at a time, runs a single bus cycle, stalls
// the pipeline until ack and hands load data back on cpu_data_o. Hung cycles
// are aborted after TIMEOUT_CYCLES busy cycles with a one-cycle bus_err_o.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   stall_i, flush_i    pipeline control from ctrl
//   cpu_ce_i/we/sel/addr/data   request from the mem stage
//   cpu_data_o          load data back to the mem stage
//   stallreq_o          stall request to ctrl
//   bus_err_o           one-cycle pulse when a cycle is aborted by timeout
//   wb_*_o / wb_*_i     Wishbone master interface (outputs registered)
// ---------------------------------------------------------------------------
module wb_dbus_master
    import wb_dbus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STALL_W        = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [3:0]         cpu_sel_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_data_i,
    output logic [31:0]        cpu_data_o,
    output logic               stallreq_o,
    output logic               bus_err_o,
    output logic [31:0]        wb_adr_o,
    output logic [31:0]        wb_dat_o,
    output logic [3:0]         wb_sel_o,
    output logic               wb_we_o,
    output logic               wb_stb_o,
    output logic               wb_cyc_o,
    input  logic [31:0]        wb_dat_i,
    input  logic               wb_ack_i
);

    // Counter value seen in the last busy cycle before the abort.
    localparam logic [TMO_W-1:0] TMO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TMO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_reg;
    wb_req_t          bus_reg;
    logic [31:0]      rd_buf_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             bus_err_reg;
    logic             tmo_hit;

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_reg == TMO_LAST);

    assign wb_cyc_o  = bus_reg.cyc;
    assign wb_stb_o  = bus_reg.stb;
    assign wb_we_o   = bus_reg.we;
    assign wb_sel_o  = bus_reg.sel;
    assign wb_adr_o  = bus_reg.adr;
    assign wb_dat_o  = bus_reg.dat;
    assign bus_err_o = bus_err_reg;

    // Sequential FSM. Flush outranks ack, ack outranks timeout: a store that
    // is acked in the flush cycle has already happened on the bus, we just
    // do not report it back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= WB_IDLE;
            bus_reg     <= WB_REQ_IDLE;
            rd_buf_reg  <= ZERO_WORD;
            tmo_cnt_reg <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            bus_err_reg <= 1'b0;
            case (state_reg)
                WB_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        bus_reg.cyc <= 1'b1;
                        bus_reg.stb <= 1'b1;
                        bus_reg.we  <= cpu_we_i;
                        bus_reg.sel <= cpu_sel_i;
                        bus_reg.adr <= cpu_addr_i;
                        bus_reg.dat <= cpu_data_i;
                        tmo_cnt_reg <= '0;
                        state_reg   <= WB_BUSY;
                    end
                end
                WB_BUSY: begin
                    if (flush_i) begin
                        bus_reg    <= WB_REQ_IDLE;
                        rd_buf_reg <= ZERO_WORD;
                        state_reg  <= WB_IDLE;
                    end else if (wb_ack_i) begin
                        bus_reg <= WB_REQ_IDLE;
                        if (!bus_reg.we) begin
                            rd_buf_reg <= wb_dat_i;
                        end
                        // Hold the load result while the rest of the pipe is
                        // frozen; the mem stage samples it once stall clears.
                        state_reg <= (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
                    end else if (tmo_hit) begin
                        bus_reg     <= WB_REQ_IDLE;
                        rd_buf_reg  <= ZERO_WORD;
                        bus_err_reg <= 1'b1;
                        state_reg   <= WB_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_inc(tmo_cnt_reg);
                    end
                end
                WB_WAIT_FOR_STALL: begin
                    if ((stall_i == '0) || flush_i) begin
                        state_reg <= WB_IDLE;
                    end
                end
                default: begin
                    bus_reg   <= WB_REQ_IDLE;
                    state_reg <= WB_IDLE;
                end
            endcase
        end
    end

    // Combinational handshake back to the pipeline. In the ack cycle the
    // load data is forwarded straight from the bus so the stage can advance
    // without waiting an extra cycle for rd_buf.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = ZERO_WORD;
        case (state_reg)
            WB_IDLE: begin
                stallreq_o = cpu_ce_i && !flush_i;
            end
            WB_BUSY: begin
                if (flush_i) begin
                    stallreq_o = 1'b0;
                end else if (wb_ack_i) begin
                    stallreq_o = 1'b0;
                    cpu_data_o = bus_reg.we ? ZERO_WORD : wb_dat_i;
                end else if (tmo_hit) begin
                    stallreq_o = 1'b0;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            WB_WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf_reg;
            end
            default: begin
                stallreq_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_dbus_master.sv
// ---------------------------------------------------------------------------
// tb_wb_dbus_master
// Self-checking bench for wb_dbus_master (TIMEOUT_CYCLES = 8). The bench acts
// as both mem stage and Wishbone slave; expected load data is queued when a
// request is driven and popped in the ack cycle.
// ---------------------------------------------------------------------------
module tb_wb_dbus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wb_dbus_master #(
        .TIMEOUT_CYCLES(8),
        .STALL_W       (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .cpu_ce_i  (cpu_ce_i),
        .cpu_we_i  (cpu_we_i),
        .cpu_sel_i (cpu_sel_i),
        .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o),
        .bus_err_o (bus_err_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete transfer: request in IDLE, issue, 'delay' wait cycles,
    // ack, optional stall hold of 'stall_cycles' cycles after the ack.
    task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int delay, input int stall_cycles);
        int          n;
        int          hi;
        logic [31:0] e;
        @(posedge clk); #1;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_sel_i  = sel;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
        exp_q.push_back(we ? 32'h0 : rdata);
        @(negedge clk);
        chk("idle_stallreq", 32'(stallreq_o), 1);
        hi = 1;
        n  = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_cyc_o && n < 16);
        chk("cyc_up", 32'(wb_cyc_o), 1);
        chk("stb_up", 32'(wb_stb_o), 1);
        chk("wb_adr", wb_adr_o, addr);
        chk("wb_sel", 32'(wb_sel_o), 32'(sel));
        chk("wb_we", 32'(wb_we_o), 32'(we));
        chk("wb_dat", wb_dat_o, wdata);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            if (stallreq_o) hi++;
            @(posedge clk); #1;
        end
        if (stall_cycles > 0) stall_i = 6'b000011;
        wb_ack_i = 1'b1;
        wb_dat_i = rdata;
        @(negedge clk);
        chk("ack_stallreq", 32'(stallreq_o), 0);
        chk("stall_hi_cycles", 32'(hi), 32'(delay + 1));
        e = exp_q.pop_front();
        chk("ack_data", cpu_data_o, e);
        $display("xfer we=%0b addr=%h sel=%h wdata=%h rdata=%h delay=%0d stall=%0d",
                 we, addr, sel, wdata, cpu_data_o, delay, stall_cycles);
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0BAD_F00D;
        cpu_ce_i = 1'b0;
        chk("cyc_drop", 32'(wb_cyc_o), 0);
        chk("stb_drop", 32'(wb_stb_o), 0);
        if (stall_cycles > 0) begin
            for (int j = 0; j < stall_cycles; j++) begin
                @(negedge clk);
                chk("wait_data", cpu_data_o, rdata);
                chk("wait_stallreq", 32'(stallreq_o), 0);
                chk("wait_cyc", 32'(wb_cyc_o), 0);
                @(posedge clk); #1;
            end
            stall_i = 6'b0;
            @(negedge clk);
            chk("wait_last_data", cpu_data_o, rdata);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("idle_data", cpu_data_o, 0);
        chk("idle_stallreq_after", 32'(stallreq_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b0;
        stall_i    = 6'b0;
        flush_i    = 1'b0;
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'h0;
        cpu_addr_i = 32'h0;
        cpu_data_i = 32'h0;
        wb_dat_i   = 32'h0;
        wb_ack_i   = 1'b0;

        // Reset state
        #12;
        chk("rst_cyc", 32'(wb_cyc_o), 0);
        chk("rst_adr", wb_adr_o, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_sel", 32'(wb_sel_o), 0);
        chk("rst_bus_err", 32'(bus_err_o), 0);
        chk("rst_data", cpu_data_o, 0);
        chk("rst_stallreq", 32'(stallreq_o), 0);

        // Load word, ack after 3 wait cycles
        xfer(1'b0, 4'hF, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 3, 0);
        // Store byte, ack in first busy cycle
        xfer(1'b1, 4'b0001, 32'h0000_2003, 32'h5A5A_5A5A, 32'h1234_5678, 0, 0);
        // Load acked while the pipeline is stalled
        xfer(1'b0, 4'hF, 32'h0000_1004, 32'h0, 32'hA5A5_0F0F, 1, 3);

        // Flush together with ack in BUSY
        @(posedge clk); #1;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'hF;
        cpu_addr_i = 32'h0000_4000;
        @(posedge clk); #1;
        chk("flush_cyc_up", 32'(wb_cyc_o), 1);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hCAFE_F00D;
        flush_i  = 1'b1;
        stall_i  = 6'b000011;
        @(negedge clk);
        chk("flush_stallreq", 32'(stallreq_o), 0);
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        flush_i  = 1'b0;
        cpu_ce_i = 1'b0;
        chk("flush_cyc_drop", 32'(wb_cyc_o), 0);
        chk("flush_stb_drop", 32'(wb_stb_o), 0);
        chk("flush_bus_err", 32'(bus_err_o), 0);
        @(negedge clk);
        chk("flush_no_wait", cpu_data_o, 0);
        stall_i = 6'b0;
        $display("xfer flush+ack addr=00004000");

        // ce and flush together in IDLE: no cycle
        @(posedge clk); #1;
        cpu_ce_i = 1'b1;
        flush_i  = 1'b1;
        @(negedge clk);
        chk("ce_flush_stallreq", 32'(stallreq_o), 0);
        @(posedge clk); #1;
        chk("ce_flush_no_cyc", 32'(wb_cyc_o), 0);
        cpu_ce_i = 1'b0;
        flush_i  = 1'b0;
        $display("xfer ce+flush in idle, no cycle");

        // Timeout: slave never acks
        @(posedge clk); #1;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_3000;
        @(posedge clk); #1;
        chk("tmo_cyc_up", 32'(wb_cyc_o), 1);
        n = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (stallreq_o) n++;
            if (k == 3) chk("tmo_no_err_early", 32'(bus_err_o), 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tmo_hi_cycles", 32'(n), 7);
        chk("tmo_last_stallreq", 32'(stallreq_o), 0);
        chk("tmo_last_data", cpu_data_o, 0);
        cpu_ce_i = 1'b0;
        @(posedge clk); #1;
        chk("tmo_bus_err", 32'(bus_err_o), 1);
        chk("tmo_cyc_drop", 32'(wb_cyc_o), 0);
        @(posedge clk); #1;
        chk("tmo_bus_err_pulse", 32'(bus_err_o), 0);
        $display("xfer timeout addr=00003000");
        xfer(1'b0, 4'hF, 32'h0000_3004, 32'h0, 32'h0F1E_2D3C, 2, 0);

        // A few random loads through the scoreboard
        for (int r = 0; r < 6; r++) begin
            xfer(1'b0, 4'hF, $urandom & 32'hFFFF_FFFC, 32'h0, $urandom, $urandom_range(0, 3), 0);
        end

        // Asynchronous reset mid-BUSY
        @(posedge clk); #1;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b1;
        cpu_sel_i  = 4'hC;
        cpu_addr_i = 32'h0000_5000;
        cpu_data_i = 32'h1111_2222;
        @(posedge clk); #1;
        chk("arst_cyc_up", 32'(wb_cyc_o), 1);
        cpu_ce_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cyc", 32'(wb_cyc_o), 0);
        chk("arst_stb", 32'(wb_stb_o), 0);
        chk("arst_we", 32'(wb_we_o), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_post_cyc", 32'(wb_cyc_o), 0);
        chk("arst_post_adr", wb_adr_o, 0);
        chk("arst_post_err", 32'(bus_err_o), 0);
        @(negedge clk);
        chk("arst_post_stallreq", 32'(stallreq_o), 0);
        chk("arst_post_data", cpu_data_o, 0);
        $display("xfer async reset during busy");

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
